// File: rtl/tanh_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tanh_pkg
//  Brief    : Shared constants, types and tanh breakpoint table for the
//             LSTM tanh activation path (fetch stage and interpolator).
//  Revision : 1.0  initial release
// ============================================================================
package tanh_pkg;

  // Sample / table entry width and number of fractional bits (Q4.4).
  localparam int DATA_W    = 8;
  localparam int FRAC_W    = 4;

  // Breakpoints cover integer points -8..8 inclusive.
  localparam int TBL_DEPTH = 17;

  // Width of the integer (segment index) part of a sample.
  localparam int IDX_W     = DATA_W - FRAC_W;

  // Address width needed to reach all TBL_DEPTH entries.
  localparam int ADDR_W    = $clog2(TBL_DEPTH);

  // Offset that maps the signed index -8 onto table address 0.
  localparam int TBL_BIAS  = TBL_DEPTH / 2;

  // Signed Q4.4 value.
  typedef logic signed [DATA_W-1:0] q44_t;

  // round(16 * tanh(p)) for p = -8 .. 8. Odd symmetry around entry 8 is exact.
  localparam q44_t TANH_TBL [TBL_DEPTH] = '{
    -8'sd16, -8'sd16, -8'sd16, -8'sd16, -8'sd16, -8'sd16, -8'sd15, -8'sd12,
     8'sd0,
     8'sd12,  8'sd15,  8'sd16,  8'sd16,  8'sd16,  8'sd16,  8'sd16,  8'sd16
  };

  // Convert a signed segment index into a table address (index + bias).
  // Sign-extending the index before adding the bias keeps negative indices
  // landing on the low half of the table.
  function automatic logic [ADDR_W-1:0] idx_to_addr(input logic signed [IDX_W-1:0] idx);
    logic signed [ADDR_W-1:0] idx_ext;
    idx_ext = ADDR_W'(idx);
    return ADDR_W'(idx_ext) + ADDR_W'(TBL_BIAS);
  endfunction

  // Constant table read; addresses beyond the last breakpoint return zero so
  // the lookup is fully defined for every address code.
  function automatic q44_t tbl_read(input logic [ADDR_W-1:0] addr);
    q44_t val;
    val = '0;
    if (addr < ADDR_W'(TBL_DEPTH)) begin
      val = TANH_TBL[addr];
    end
    return val;
  endfunction

endpackage : tanh_pkg
`default_nettype wire

// File: rtl/tanh_rom.sv
`default_nettype none
// ============================================================================
//  Module   : tanh_rom
//  Brief    : Combinational two-read-port constant lookup into the tanh
//             breakpoint table. Pure logic, no storage.
//  Revision : 1.0  initial release
// ============================================================================
module tanh_rom
  import tanh_pkg::*;
(
  input  logic [ADDR_W-1:0] addr_a_i,
  input  logic [ADDR_W-1:0] addr_b_i,
  output q44_t              data_a_o,
  output q44_t              data_b_o
);

  // Port A: breakpoint at the lower end of the segment.
  always_comb begin
    data_a_o = tbl_read(addr_a_i);
  end

  // Port B: breakpoint at the upper end of the segment.
  always_comb begin
    data_b_o = tbl_read(addr_b_i);
  end

endmodule : tanh_rom
`default_nettype wire

// File: rtl/tanh_lut_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tanh_lut_fetch
//  Brief    : Feeder for the tanh linear interpolator. Splits a signed Q4.4
//             sample into segment index and fractional remainder, fetches the
//             two bracketing breakpoints and presents base / next_data /
//             change / remaining from a 2-stage valid/ready pipeline.
//  Revision : 1.0  initial release
// ============================================================================
module tanh_lut_fetch #(
  parameter int DATA_W = tanh_pkg::DATA_W,
  parameter int FRAC_W = tanh_pkg::FRAC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] x,
  input  logic              valid_in,
  output logic              ready_in,
  output logic [DATA_W-1:0] base,
  output logic [DATA_W-1:0] next_data,
  output logic [DATA_W-1:0] change,
  output logic [DATA_W-1:0] remaining,
  output logic              valid_out,
  input  logic              ready_out
);

  import tanh_pkg::ADDR_W;
  import tanh_pkg::q44_t;
  import tanh_pkg::idx_to_addr;

  localparam int SEG_W = DATA_W - FRAC_W;

  // --------------------------------------------------------------------------
  // Pipeline state
  // --------------------------------------------------------------------------
  logic                    adv;

  logic                    v1_q,   v1_d;
  logic signed [SEG_W-1:0] idx1_q, idx1_d;
  logic [FRAC_W-1:0]       rem1_q, rem1_d;

  logic                    vout_q,   vout_d;
  logic [DATA_W-1:0]       base_q,   base_d;
  logic [DATA_W-1:0]       next_q,   next_d;
  logic [DATA_W-1:0]       change_q, change_d;
  logic [DATA_W-1:0]       rem2_q,   rem2_d;

  logic [ADDR_W-1:0]       addr_lo;
  logic [ADDR_W-1:0]       addr_hi;
  q44_t                    tbl_lo;
  q44_t                    tbl_hi;

  // Whole pipeline moves together: it may advance whenever the output slot is
  // empty or is being drained this cycle. Accepting and draining in the same
  // cycle therefore costs no bubble.
  assign adv      = !vout_q || ready_out;
  assign ready_in = adv;

  // --------------------------------------------------------------------------
  // Stage 1: split the sample. The upper bits taken as a signed field give
  // floor(x) directly, so negative samples index the segment below them and
  // the low bits are always the non-negative remainder.
  // --------------------------------------------------------------------------

  // Stage 1 next-state: load on advance, otherwise hold.
  always_comb begin
    v1_d   = v1_q;
    idx1_d = idx1_q;
    rem1_d = rem1_q;
    if (adv) begin
      v1_d   = valid_in;
      idx1_d = x[DATA_W-1:FRAC_W];
      rem1_d = x[FRAC_W-1:0];
    end
  end

  // Stage 1 registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      idx1_q <= '0;
      rem1_q <= '0;
    end else begin
      v1_q   <= v1_d;
      idx1_q <= idx1_d;
      rem1_q <= rem1_d;
    end
  end

  // --------------------------------------------------------------------------
  // Table lookup between the stages. Every representable index (-8..7) maps
  // onto addresses 0..15 for the low breakpoint and 1..16 for the high one,
  // so no clamping is needed.
  // --------------------------------------------------------------------------

  // Address generation for the two bracketing breakpoints.
  always_comb begin
    addr_lo = idx_to_addr(idx1_q);
    addr_hi = addr_lo + ADDR_W'(1);
  end

  tanh_rom u_rom (
    .addr_a_i (addr_lo),
    .addr_b_i (addr_hi),
    .data_a_o (tbl_lo),
    .data_b_o (tbl_hi)
  );

  // --------------------------------------------------------------------------
  // Stage 2: register breakpoints, slope and remainder. The slope never
  // exceeds 12 in magnitude, so the DATA_W subtraction cannot wrap.
  // --------------------------------------------------------------------------

  // Stage 2 next-state: load on advance, otherwise hold for the consumer.
  always_comb begin
    vout_d   = vout_q;
    base_d   = base_q;
    next_d   = next_q;
    change_d = change_q;
    rem2_d   = rem2_q;
    if (adv) begin
      vout_d   = v1_q;
      base_d   = DATA_W'(tbl_lo);
      next_d   = DATA_W'(tbl_hi);
      change_d = DATA_W'(tbl_hi) - DATA_W'(tbl_lo);
      rem2_d   = DATA_W'(rem1_q);
    end
  end

  // Stage 2 registers with synchronous reset; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      vout_q   <= 1'b0;
      base_q   <= '0;
      next_q   <= '0;
      change_q <= '0;
      rem2_q   <= '0;
    end else begin
      vout_q   <= vout_d;
      base_q   <= base_d;
      next_q   <= next_d;
      change_q <= change_d;
      rem2_q   <= rem2_d;
    end
  end

  assign valid_out = vout_q;
  assign base      = base_q;
  assign next_data = next_q;
  assign change    = change_q;
  assign remaining = rem2_q;

endmodule : tanh_lut_fetch
`default_nettype wire

// File: tb/tb_tanh_lut_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tanh_lut_fetch
//  Brief    : Self-checking bench for tanh_lut_fetch: directed corner cases,
//             backpressure, reset flush and random traffic against a
//             behavioural reference model with an in-order scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tanh_lut_fetch;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] x;
  logic       valid_in;
  logic       ready_in;
  logic [7:0] base;
  logic [7:0] next_data;
  logic [7:0] change;
  logic [7:0] remaining;
  logic       valid_out;
  logic       ready_out;

  int checks = 0;
  int errors = 0;
  int drains = 0;

  // Breakpoints round(16*tanh(p)), p = -8..8.
  int TBL [17] = '{-16, -16, -16, -16, -16, -16, -15, -12, 0,
                    12,  15,  16,  16,  16,  16,  16,  16};

  typedef struct {
    int b;
    int n;
    int c;
    int r;
  } exp_t;

  exp_t q[$];

  tanh_lut_fetch #(.DATA_W(8), .FRAC_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .base      (base),
    .next_data (next_data),
    .change    (change),
    .remaining (remaining),
    .valid_out (valid_out),
    .ready_out (ready_out)
  );

  always #5 clk = ~clk;

  // Reference: value = x/16; segment = floor(value); remainder in sixteenths.
  function automatic exp_t model(input logic [7:0] xv);
    exp_t e;
    int   xi;
    int   idx;
    xi  = int'($signed(xv));
    idx = (xi >= 0) ? (xi / 16) : -((-xi + 15) / 16);
    e.b = TBL[idx + 8];
    e.n = TBL[idx + 9];
    e.c = e.n - e.b;
    e.r = xi - 16 * idx;
    return e;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // One clock cycle: drive at the falling edge, check handshakes/drains just
  // before the rising edge, check held outputs just after it.
  task automatic step(input logic [7:0] xv, input logic vin, input logic rdy);
    exp_t e;
    logic stall;
    logic acc;
    logic [7:0] hb, hn, hc, hr;
    x         = xv;
    valid_in  = vin;
    ready_out = rdy;
    #1;
    chk("ready_in", {31'd0, ready_in}, {31'd0, (!valid_out || rdy)});
    if (valid_out && rdy) begin
      drains++;
      if (q.size() == 0) begin
        chk("spurious_valid_out", 1, 0);
      end else begin
        e = q.pop_front();
        chk("base",      $signed(base),      e.b);
        chk("next_data", $signed(next_data), e.n);
        chk("change",    $signed(change),    e.c);
        chk("remaining", remaining,          e.r);
      end
    end
    acc   = vin && (!valid_out || rdy);
    stall = valid_out && !rdy;
    hb = base; hn = next_data; hc = change; hr = remaining;
    if (acc) q.push_back(model(xv));
    @(posedge clk);
    #1;
    if (stall) begin
      chk("hold_valid",     {31'd0, valid_out}, 1);
      chk("hold_base",      base,      hb);
      chk("hold_next",      next_data, hn);
      chk("hold_change",    change,    hc);
      chk("hold_remaining", remaining, hr);
    end
    @(negedge clk);
  endtask

  // Single sample through an empty pipe: exact 2-cycle latency and literal values.
  task automatic directed(input logic [7:0] xv, input int eb, input int en,
                          input int ec, input int er);
    step(xv, 1'b1, 1'b1);
    chk("latency_early", {31'd0, valid_out}, 0);
    step(8'h00, 1'b0, 1'b0);
    chk("latency_valid", {31'd0, valid_out}, 1);
    chk("dir_base",   $signed(base),      eb);
    chk("dir_next",   $signed(next_data), en);
    chk("dir_change", $signed(change),    ec);
    chk("dir_rem",    remaining,          er);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    logic [7:0] rx;

    // ---- Reset state ----
    rst = 1'b1; x = 8'h00; valid_in = 1'b0; ready_out = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_valid_out", {31'd0, valid_out}, 0);
    chk("rst_base",      base,      0);
    chk("rst_next",      next_data, 0);
    chk("rst_change",    change,    0);
    chk("rst_remaining", remaining, 0);
    chk("rst_ready_in",  {31'd0, ready_in}, 1);
    @(negedge clk);

    // ---- Directed samples and extremes ----
    directed(8'h18,  12,  15,  3,  8);
    directed(8'hF8, -12,   0, 12,  8);
    directed(8'h80, -16, -16,  0,  0);
    directed(8'h7F,  16,  16,  0, 15);
    directed(8'h00,   0,  12, 12,  0);
    step(8'h00, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b1);
    chk("dir_queue_empty", q.size(), 0);

    // ---- Backpressure ----
    step(8'h10, 1'b1, 1'b1);
    step(8'h20, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(8'h30, 1'b1, 1'b0);
      chk("bp_ready_in", {31'd0, ready_in}, 0);
      chk("bp_base",     $signed(base),      12);
      chk("bp_next",     $signed(next_data), 15);
    end
    step(8'h30, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(8'h00, 1'b0, 1'b1);
    chk("bp_queue_empty", q.size(), 0);

    // ---- Back-to-back random stream of 16 ----
    d0 = drains;
    for (int i = 0; i < 18; i++) begin
      if (i >= 2) chk("b2b_valid", {31'd0, valid_out}, 1);
      rx = 8'($urandom);
      step(rx, (i < 16), 1'b1);
    end
    chk("b2b_count", drains - d0, 16);
    step(8'h00, 1'b0, 1'b1);

    // ---- Reset with two samples in flight ----
    step(8'h33, 1'b1, 1'b1);
    step(8'h44, 1'b1, 1'b1);
    x = 8'h55; valid_in = 1'b1; ready_out = 1'b1; rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    chk("mid_rst_valid_out", {31'd0, valid_out}, 0);
    chk("mid_rst_base",      base,      0);
    chk("mid_rst_next",      next_data, 0);
    chk("mid_rst_change",    change,    0);
    chk("mid_rst_remaining", remaining, 0);
    chk("mid_rst_ready_in",  {31'd0, ready_in}, 1);
    @(negedge clk);
    d0 = drains;
    for (int i = 0; i < 4; i++) step(8'h00, 1'b0, 1'b1);
    chk("mid_rst_no_ghost", drains - d0, 0);

    // ---- Random traffic with random backpressure ----
    for (int i = 0; i < 300; i++) begin
      rx = 8'($urandom);
      step(rx, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 4; i++) step(8'h00, 1'b0, 1'b1);
    chk("final_queue_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_tanh_lut_fetch
`default_nettype wire
